// File: rtl/led_pwm_bank.sv
// led_pwm_bank: multi-channel LED driver for the board top levels.
// Each channel gates its raw status bit with a PWM duty cycle. The duty is
// shadowed so that it only changes at a period boundary. Each channel has
// its own display mode: off, direct, pulse-stretched or blink.
//
// Ports
//   clock    : block clock (slow domain)
//   res      : synchronous active-high reset; overrides every other input
//   tick     : advance strobe; the PWM, blink and stretch counters move only on tick
//   led_in   : [NUM_LEDS] raw status bits
//   duty     : [NUM_LEDS*PWM_BITS] per-channel duty, channel i at [i*PWM_BITS +: PWM_BITS]
//   mode     : [2*NUM_LEDS] per-channel mode, channel i at [2i +: 2]
//              00 off, 01 direct, 10 stretched, 11 blink
//   led_out  : [NUM_LEDS] registered LED drive
//   pwm_wrap : one-cycle strobe after the tick that wraps the PWM counter

module led_pwm_bank #(
  parameter int NUM_LEDS     = 8,
  parameter int PWM_BITS     = 3,
  parameter int STRETCH_BITS = 10,
  parameter int BLINK_BITS   = 4
) (
  input  logic                         clock,
  input  logic                         res,
  input  logic                         tick,
  input  logic [NUM_LEDS-1:0]          led_in,
  input  logic [NUM_LEDS*PWM_BITS-1:0] duty,
  input  logic [2*NUM_LEDS-1:0]        mode,
  output logic [NUM_LEDS-1:0]          led_out,
  output logic                         pwm_wrap
);

  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  wrap_tick;
  logic                  blink_phase;

  // This is the tick on which the counter leaves all-ones. Shadow duties load
  // on it, and the blink counter advances on it.
  assign wrap_tick   = tick & (&pwm_cnt);
  assign blink_phase = blink_cnt[BLINK_BITS-1];

  always_ff @(posedge clock) begin
    if (res) begin
      pwm_cnt   <= '0;
      blink_cnt <= '0;
      pwm_wrap  <= 1'b0;
    end else begin
      pwm_wrap <= wrap_tick;
      if (tick)      pwm_cnt   <= pwm_cnt + 1'b1;
      if (wrap_tick) blink_cnt <= blink_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
    led_pwm_chan #(
      .PWM_BITS     (PWM_BITS),
      .STRETCH_BITS (STRETCH_BITS)
    ) u_chan (
      .clock       (clock),
      .res         (res),
      .tick        (tick),
      .wrap_tick   (wrap_tick),
      .pwm_cnt     (pwm_cnt),
      .blink_phase (blink_phase),
      .led_in      (led_in[g]),
      .duty        (duty[g*PWM_BITS +: PWM_BITS]),
      .mode        (mode[2*g +: 2]),
      .led_out     (led_out[g])
    );
  end

endmodule

// led_pwm_chan: one channel of the bank. It holds the shadow duty, the
// edge-triggered pulse stretcher and the registered output mux.
//   clock, res, tick : as in the parent
//   wrap_tick        : PWM wrap tick from the shared counter
//   pwm_cnt          : shared PWM counter
//   blink_phase      : shared blink phase
//   led_in, duty, mode : this channel's slice of the parent inputs
//   led_out          : registered drive for this channel
module led_pwm_chan #(
  parameter int PWM_BITS     = 3,
  parameter int STRETCH_BITS = 10
) (
  input  logic                clock,
  input  logic                res,
  input  logic                tick,
  input  logic                wrap_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                blink_phase,
  input  logic                led_in,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [1:0]          mode,
  output logic                led_out
);

  logic [PWM_BITS-1:0]     shadow;
  logic [STRETCH_BITS-1:0] stretch_cnt;
  logic                    led_in_q;
  logic                    rise;
  logic                    gate;
  logic                    stretched;
  logic                    drive;

  assign rise      = led_in & ~led_in_q;
  // A duty of all-ones means fully on, not (2^N-1)/2^N.
  assign gate      = (&shadow) | (pwm_cnt < shadow);
  assign stretched = led_in | (stretch_cnt != '0);

  always_comb begin
    drive = 1'b0;
    case (mode)
      2'b00: drive = 1'b0;
      2'b01: drive = led_in & gate;
      2'b10: drive = stretched & gate;
      2'b11: drive = led_in & blink_phase & gate;
      default: drive = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    // The edge detector follows led_in through reset. A level held high
    // across reset therefore does not look like a new edge afterwards.
    led_in_q <= led_in;
    if (res) begin
      shadow      <= '0;
      stretch_cnt <= '0;
      led_out     <= 1'b0;
    end else begin
      if (wrap_tick) shadow <= duty;
      // Edges load regardless of tick, and a load wins over the decrement.
      if (rise)
        stretch_cnt <= '1;
      else if (tick && (stretch_cnt != '0))
        stretch_cnt <= stretch_cnt - 1'b1;
      led_out <= drive;
    end
  end

endmodule

// File: doc/led_pwm_bank.md
Name: led_pwm_bank

Overview:
- Parametrised multi-channel LED driver that replaces the fixed 3-bit, single-duty dimmer in the board top levels.
- Each channel takes a raw status bit, e.g. a cog LED or a reset or prop-plug indicator.
- Each channel gets its own duty cycle and display mode: off, direct, pulse-stretched or blink.
- Instantiated once per board top level between the core's status outputs and the physical LED pins, clocked from the slow clock domain.

Parameters:
- NUM_LEDS, 8, number of independent channels.
- PWM_BITS, 3, width of the PWM counter and of each duty field.
- STRETCH_BITS, 10, width of each channel's pulse-stretch down-counter.
- BLINK_BITS, 4, width of the blink-phase counter, which advances once per PWM period.

Ports:
- clock, input, 1, block clock.
- res, input, 1, synchronous active-high reset.
- tick, input, 1, single-cycle advance strobe. All counters move only when tick=1. Tie high to run at clock rate.
- led_in, input, NUM_LEDS, raw status bits, synchronous to clock.
- duty, input, NUM_LEDS*PWM_BITS, per-channel duty. Channel i uses bits [i*PWM_BITS +: PWM_BITS].
- mode, input, 2*NUM_LEDS, per-channel mode. Channel i uses bits [2i +: 2].
- led_out, output, NUM_LEDS, registered LED drive.
- pwm_wrap, output, 1, one-cycle strobe when the PWM counter wraps.

Behaviour:
- Reset (res=1 at a clock edge) clears:
  - pwm_cnt, blink_cnt and all stretch counters;
  - all shadow duty registers;
  - led_out and pwm_wrap.
  - res has priority over tick and over every other input.
- PWM counter:
  - pwm_cnt is PWM_BITS wide and increments on each tick.
  - It wraps from 2^PWM_BITS-1 to 0.
  - pwm_wrap is registered: it is 1 in the cycle after the tick that moved pwm_cnt from all-ones to 0, and 0 otherwise.
- Duty shadowing:
  - Each channel holds a shadow duty register.
  - The shadow loads from the duty input only on the wrapping tick, so no partial period is ever produced.
  - Duty changes between wraps are ignored until the next wrap.
- PWM gate: gate[i] = (pwm_cnt < shadow_duty[i]), except shadow_duty[i] == all-ones forces gate[i]=1 (100%).
  - duty 0 gives 0% on time.
  - duty k, for 0<k<max, gives k of 2^PWM_BITS ticks on.
- Blink counter:
  - blink_cnt is BLINK_BITS wide and increments on each wrapping tick, wrapping to 0.
  - blink_phase is the MSB of blink_cnt.
- Stretch, per channel:
  - A rising edge of led_in[i] (registered previous value 0, current value 1) loads the counter to 2^STRETCH_BITS-1. This happens regardless of tick.
  - Otherwise the counter decrements on tick while nonzero, saturating at 0.
  - An edge that coincides with a tick loads; it does not decrement.
  - A retrigger while the counter is nonzero reloads it.
  - stretched[i] = led_in[i] | (stretch_cnt[i] != 0).
- Mode per channel:
  - 00: off, led_out 0.
  - 01: direct, led_in & gate.
  - 10: stretched, stretched & gate.
  - 11: blink, led_in & blink_phase & gate.
  - Mode changes take effect on the next clock edge; they are not shadowed.
- Latency: led_out is registered, so it reflects inputs and counter state from the previous edge (1 cycle). In-flight state is not affected by a mode change; stretch counters keep running in every mode.
- Reset mid-operation:
  - A stretch in progress is cancelled and blink phase restarts at 0.
  - The shadow duty returns to 0, so outputs stay 0 until the first wrap after reset.
  - The first wrap after reset occurs 2^PWM_BITS ticks after res deasserts.
- Widths: all comparisons are unsigned. NUM_LEDS=1 and PWM_BITS=1 must elaborate and function.

Test Plan:
- Reset, then PWM_BITS=3, tick=1, duty ch0=3, mode=01, led_in=1 held: first 8 cycles led_out[0]=0 (shadow 0). After wrap, led_out[0]=1 for exactly 3 of every 8 cycles. pwm_wrap pulses every 8 cycles.
- Duty ch0 changed from 3 to 6 when pwm_cnt=4: current period keeps 3 on-cycles, next period shows 6. Set duty=7: led_out[0] constant 1 after the following wrap.
- Stretch: STRETCH_BITS=4, mode=10, duty=7, tick=1, led_in 1-cycle pulse. Then led_out high for the pulse plus 15 ticks, then 0.
  - Retrigger at count 5: the high interval extends to 15 ticks after the second edge.
  - Same pulse with tick=0: the counter holds at 15 and led_out stays high.
- Blink: BLINK_BITS=2, PWM_BITS=1, duty=1 (all-ones, full on), mode=11, led_in=1 → led_out 0 for 4 ticks, 1 for 4 ticks, repeating. Mode=00 → led_out 0 on the next cycle.
- Reset mid-stretch, with the counter at 9: led_out=0 the cycle after res. The stretch does not resume after res deasserts. pwm_cnt, blink_cnt and pwm_wrap all read 0.
- Independence, NUM_LEDS=8, distinct duty/mode per channel: each channel's on-count per period matches its own duty. No cross-channel interference when toggling ch3's led_in every cycle.
